// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants and data width for the 4-bit ALU pipeline
// Contents: DATA_W (operand/result width) and the 3-bit opcode map OP_ADD..OP_DEC.

package alu_pkg;

  localparam int DATA_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

endpackage

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - combinational 4-bit ALU datapath (result only, no flags)
// Ports:
//   a, b : operands (b unused by NOT/INC/DEC)
//   sel  : opcode from alu_pkg
//   y    : result, wrapping modulo 2**DATA_W

module alu_4bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_INC: y = a + 1'b1;
      OP_DEC: y = a - 1'b1;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_4bit_pipe.sv
// rtl/alu_4bit_pipe.sv - two-stage valid/ready pipelined 4-bit ALU with carry/zero flags
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake for A, B, sel
//   A, B, sel           : operands and opcode
//   out_valid, out_ready: response handshake for result, carry, zero
//   result, carry, zero : registered stage-2 outputs
//   op_count            : completed responses, wraps at 256

module alu_4bit_pipe
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic [7:0]        op_count
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [2:0]        s1_sel;
  logic              s2_valid;

  logic              s1_adv;
  logic              accept;
  logic              done;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic              alu_z;

  // S1 moves into S2 whenever S2 is empty or is being drained this cycle,
  // so a completing response and an advancing request overlap with no bubble.
  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s1_adv;
  assign accept    = in_valid && in_ready;
  assign done      = s2_valid && out_ready;
  assign out_valid = s2_valid;

  alu_4bit u_alu (
    .a   (s1_a),
    .b   (s1_b),
    .sel (s1_sel),
    .y   (alu_y)
  );

  // Add carry-out is detected as wrap-around: the truncated sum is smaller than a.
  always_comb begin
    alu_c = 1'b0;
    case (s1_sel)
      OP_ADD:  alu_c = (s1_a + s1_b) < s1_a;
      OP_SUB:  alu_c = s1_a < s1_b;
      OP_INC:  alu_c = &s1_a;
      OP_DEC:  alu_c = ~|s1_a;
      default: alu_c = 1'b0;
    endcase
  end

  assign alu_z = (alu_y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= OP_ADD;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= A;
        s1_b     <= B;
        s1_sel   <= sel;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      op_count <= 8'd0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        result   <= alu_y;
        carry    <= alu_c;
        zero     <= alu_z;
      end else if (done) begin
        s2_valid <= 1'b0;
      end
      if (done) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_4bit_pipe.sv
// tb/tb_alu_4bit_pipe.sv - directed and random self-checking bench for alu_4bit_pipe

module tb_alu_4bit_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic [7:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp38 [8];
  logic [5:0] q [$];
  logic [5:0] exp_rsp;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [2:0] rs;
  int         sent;
  int         done_n;
  int         cyc;

  always #5 clk = ~clk;

  alu_4bit_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    in_valid = v;
    A        = a;
    B        = b;
    sel      = s;
  endtask

  // Reference: returns {result, carry, zero}.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    logic [4:0] wide;
    logic [3:0] r;
    logic       c;
    r = 4'h0;
    c = 1'b0;
    case (s)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[3:0]; c = wide[4]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = a + 4'd1; c = (a == 4'hF); end
      default: begin r = a - 4'd1; c = (a == 4'h0); end
    endcase
    return {r, c, (r == 4'h0)};
  endfunction

  task automatic send_and_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                                input logic [2:0] s, input logic [3:0] er, input logic ec, input logic ez);
    @(negedge clk); drive(1'b1, a, b, s);
    @(negedge clk); drive(1'b0, a, b, s);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp38[0] = 4'hF; exp38[1] = 4'h5; exp38[2] = 4'h0; exp38[3] = 4'hF;
    exp38[4] = 4'hF; exp38[5] = 4'h5; exp38[6] = 4'hB; exp38[7] = 4'h9;

    // Reset state
    rst_n = 1'b1; out_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, OP_ADD);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_result", 32'(result), 0);
    check("rst_carry", 32'(carry), 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_op_count", 32'(op_count), 0);
    @(negedge clk); rst_n = 1'b1;

    // All opcodes back-to-back, A=1010 B=0101, one result per cycle from accept+2
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 10) begin
        check("s038_valid", 32'(out_valid), 1);
        check("s038_result", 32'(result), 32'(exp38[k-2]));
        check("s038_carry", 32'(carry), 0);
        check("s038_zero", 32'(zero), 32'(exp38[k-2] == 4'h0));
      end
      if (k == 10) check("s038_drained", 32'(out_valid), 0);
      if (k < 8) begin
        check("s038_in_ready", 32'(in_ready), 1);
        drive(1'b1, 4'hA, 4'h5, k[2:0]);
      end else begin
        drive(1'b0, 4'h0, 4'h0, OP_ADD);
      end
    end
    check("s038_op_count", 32'(op_count), 8);

    // Carry / zero boundaries; B differs from 0 on inc/dec to show it is ignored
    send_and_check("s039_add_ovf", 4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b1);
    send_and_check("s039_inc_ovf", 4'hF, 4'h5, OP_INC, 4'h0, 1'b1, 1'b1);
    send_and_check("s039_dec_unf", 4'h0, 4'h7, OP_DEC, 4'hF, 1'b1, 1'b0);
    send_and_check("s039_sub_brw", 4'h3, 4'h5, OP_SUB, 4'hE, 1'b1, 1'b0);

    // Backpressure: three requests with out_ready low
    @(negedge clk);
    check("s040_idle", 32'(out_valid), 0);
    check("s040_op_count_before", 32'(op_count), 12);
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 4'h4, OP_ADD);
    #1 check("s040_rdy0", 32'(in_ready), 1);
    @(negedge clk);
    drive(1'b1, 4'h2, 4'h5, OP_SUB);
    #1 check("s040_rdy1", 32'(in_ready), 1);
    @(negedge clk);
    drive(1'b1, 4'hC, 4'hA, OP_XOR);
    #1 check("s040_rdy_full", 32'(in_ready), 0);
    check("s040_head_valid", 32'(out_valid), 1);
    check("s040_head_result", 32'(result), 7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("s040_hold_ready", 32'(in_ready), 0);
      check("s040_hold_valid", 32'(out_valid), 1);
      check("s040_hold_result", 32'(result), 7);
      check("s040_hold_carry", 32'(carry), 0);
      check("s040_hold_count", 32'(op_count), 12);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("s040_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    check("s040_drain1_result", 32'(result), 'hD);
    check("s040_drain1_carry", 32'(carry), 1);
    drive(1'b0, 4'h0, 4'h0, OP_ADD);
    @(negedge clk);
    check("s040_drain2_valid", 32'(out_valid), 1);
    check("s040_drain2_result", 32'(result), 6);
    check("s040_drain2_carry", 32'(carry), 0);
    check("s040_drain2_zero", 32'(zero), 0);
    @(negedge clk);
    check("s040_empty", 32'(out_valid), 0);
    check("s040_op_count", 32'(op_count), 15);

    // Reset with two ops in flight
    out_ready = 1'b0;
    @(negedge clk); drive(1'b1, 4'h5, 4'h5, OP_SUB);
    @(negedge clk); drive(1'b1, 4'h1, 4'h2, OP_ADD);
    @(negedge clk); drive(1'b0, 4'h0, 4'h0, OP_ADD);
    #1 check("s042_inflight", 32'(out_valid), 1);
    check("s042_inflight_zero", 32'(zero), 1);
    rst_n = 1'b0;
    #1;
    check("s042_rst_valid", 32'(out_valid), 0);
    check("s042_rst_count", 32'(op_count), 0);
    check("s042_rst_result", 32'(result), 0);
    check("s042_rst_zero", 32'(zero), 0);
    check("s042_rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s042_no_stale", 32'(out_valid), 0);
    end

    // Random handshakes against the reference model
    sent = 0; done_n = 0; cyc = 0;
    while (done_n < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        rs = 3'($urandom_range(0, 7));
        drive(1'b1, ra, rb, rs);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("s041_unexpected_resp", 32'(out_valid), 0);
        end else begin
          exp_rsp = q.pop_front();
          check("s041_resp", 32'({result, carry, zero}), 32'(exp_rsp));
        end
        done_n++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(A, B, sel));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("s041_done", done_n, 1000);
    check("s041_queue_empty", q.size(), 0);
    check("s041_op_count", 32'(op_count), 232);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_4bit_pipe.md
ALU_4BIT_PIPE -- requirements
Module: alu_4bit_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request operands and opcode are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a request this cycle.
REQ-005 SHALL have port A, input, 4 bits: operand A.
REQ-006 SHALL have port B, input, 4 bits: operand B.
REQ-007 SHALL have port sel, input, 3 bits: opcode.
REQ-008 SHALL have port out_valid, output, 1 bit: result, carry and zero are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the response this cycle.
REQ-010 SHALL have port result, output, 4 bits: operation result.
REQ-011 SHALL have port carry, output, 1 bit: carry or borrow flag.
REQ-012 SHALL have port zero, output, 1 bit: high when result == 0.
REQ-013 SHALL have port op_count, output, 8 bits: count of completed responses.

Function
REQ-014 Opcode map SHALL be: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A+1, 111 A-1.
REQ-015 All arithmetic SHALL wrap modulo 16.
REQ-016 carry SHALL be: add = bit-4 carry-out; sub = 1 iff A<B (unsigned); inc = 1 iff A==1111; dec = 1 iff A==0000; logic ops = 0.
REQ-017 B SHALL be ignored for opcodes 101-111.
REQ-018 Pipeline SHALL have two stages: S1 registers {A, B, sel}; S2 registers the computed {result, carry, zero}.
REQ-019 A request SHALL be accepted exactly on a cycle where in_valid && in_ready.
REQ-020 in_ready SHALL equal !s1_valid || s1_adv.
REQ-021 s1_adv SHALL equal s1_valid && (!s2_valid || out_ready).
REQ-022 A response SHALL complete exactly on a cycle where out_valid && out_ready.
REQ-023 out_valid SHALL equal s2_valid.
REQ-024 Latency SHALL be: a request accepted in cycle N gives out_valid in cycle N+2 when not stalled.
REQ-025 Throughput SHALL be 1 op/cycle with out_ready held high.
REQ-026 While out_valid && !out_ready, result/carry/zero SHALL hold stable and S2 SHALL not be overwritten.
REQ-027 While stalled, S1 SHALL hold at most one further request, after which in_ready = 0.
REQ-028 Order SHALL be preserved: responses appear in acceptance order, none dropped, none duplicated.
REQ-029 Simultaneous response complete and S1 advance SHALL load S2 in the same cycle, with no bubble.
REQ-030 op_count SHALL increment on each completed response and wrap 255 -> 0.
REQ-031 Inputs presented while in_ready = 0 SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid and op_count, and set result = 0000, carry = 0, zero = 0.
REQ-033 in_ready SHALL be 1 during and after reset.
REQ-034 Reset mid-operation SHALL discard all in-flight requests; no response SHALL appear after release until a new accept.

Structure
REQ-035 Package alu_pkg SHALL hold the 3-bit opcode constants (OP_ADD ... OP_DEC) and the data width (4).
REQ-036 Stage-2 result computation SHALL instantiate the existing combinational alu_4bit as its sole sub-module.
REQ-037 carry and zero SHALL be computed locally in alu_4bit_pipe.

Verification
REQ-038 Scenario: A=1010, B=0101, sel 000..111 back-to-back with out_ready=1 -> results 1111, 0101, 0000(z=1), 1111, 1111, 0101, 1011, 1001, all carry=0, one per cycle from accept+2.
REQ-039 Scenario: A=1111, B=0001, add -> 0000, c=1, z=1; inc A=1111 -> 0000, c=1, z=1; dec A=0000 -> 1111, c=1; sub 0011-0101 -> 1110, c=1.
REQ-040 Scenario: 3 requests with out_ready=0 -> in_ready drops after the 2nd accept; outputs hold stable; releasing out_ready drains in order with no loss.
REQ-041 Scenario: random in_valid/out_ready for 1000 ops checked against a reference model -> zero mismatches, op_count = 1000 mod 256 = 232.
REQ-042 Scenario: rst_n pulsed low with 2 ops in flight -> out_valid = 0 immediately, op_count = 0, no stale response after release.
